// File: rtl/ysyx_25040105_imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   - imem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   - NOP_INST     : word returned on an access fault (addi x0, x0, 0)
//   - WORD_BYTES   : bytes per store word
//   - addr_check() : byte address -> {err, word index}, used by both the
//                    fetch path and the load path so they decode identically
package ysyx_25040105_imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int unsigned WORD_BYTES = 4;

    // word holds the full offset/4; callers keep only the low DEPTH_LOG2 bits.
    typedef struct packed {
        logic        err;
        logic [29:0] word;
    } addr_chk_t;

    // The offset is a 32-bit wraparound subtraction, so an address below the
    // base becomes a huge offset and lands in the out-of-range test.
    function automatic addr_chk_t addr_check(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth_log2
    );
        logic [31:0] offset;
        addr_chk_t   r;
        offset = addr - base;
        r.word = offset[31:2];
        r.err  = (addr[1:0] != 2'b00) ||
                 ((offset >> (depth_log2 + $clog2(WORD_BYTES))) != 32'd0);
        return r;
    endfunction

endpackage

// File: rtl/ysyx_25040105_imem_array.sv
// Instruction word store: 2^DEPTH_LOG2 x 32 bits.
//   clk       : clock
//   wr_en_i   : write strobe, wr_data_i written to wr_idx_i on the rising edge
//   wr_idx_i  : write word index
//   wr_data_i : write data
//   rd_idx_i  : read word index
//   rd_data_o : read data (combinational; old contents during a same-edge write)
// Kept separate from the control FSM so it can be replaced by an SRAM macro.
module ysyx_25040105_imem_array #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_idx_i,
    input  logic [31:0]           wr_data_i,
    input  logic [DEPTH_LOG2-1:0] rd_idx_i,
    output logic [31:0]           rd_data_o
);

    // Contents are deliberately not reset; the loader fills the program image.
    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_idx_i];

endmodule

// File: rtl/ysyx_25040105_imem_responder.sv
// Instruction-memory responder for the IFU: accepts one fetch at a time,
// answers LATENCY cycles after the accept cycle (LATENCY legal range 1..15).
//   clk, rst                    : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr: fetch request handshake, byte address (PC)
//   resp_valid/resp_ready       : response handshake
//   resp_inst/resp_err          : fetched word / access fault (NOP on fault)
//   load_en/load_addr/load_data : loader write port, usable in any state
module ysyx_25040105_imem_responder
    import ysyx_25040105_imem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    // WAIT lasts LATENCY-1 cycles: the counter is loaded with LATENCY-2 and
    // RESP is entered on the edge where it reads zero.
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    imem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic        enter_resp;

    logic [31:0] rd_addr;
    addr_chk_t   rd_chk;
    addr_chk_t   ld_chk;
    logic [31:0] rd_data;
    logic        wr_en;

    // With LATENCY==1 the store is read on the accept edge itself, so the
    // live request address must feed the decoder while idle.
    assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign rd_chk  = addr_check(rd_addr, BASE_ADDR, DEPTH_LOG2);
    assign ld_chk  = addr_check(load_addr, BASE_ADDR, DEPTH_LOG2);
    assign wr_en   = load_en && !ld_chk.err;

    // Upper index bits are always zero for in-range accesses.
    logic unused_idx_bits;
    assign unused_idx_bits = ^{rd_chk.word[29:DEPTH_LOG2], ld_chk.word[29:DEPTH_LOG2]};

    ysyx_25040105_imem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_idx_i  (ld_chk.word[DEPTH_LOG2-1:0]),
        .wr_data_i (load_data),
        .rd_idx_i  (rd_chk.word[DEPTH_LOG2-1:0]),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The response is captured once, on the edge into RESP, and then
        // held through any backpressure.
        if (enter_resp) begin
            err_d  = rd_chk.err;
            inst_d = rd_chk.err ? NOP_INST : rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            inst_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_inst  = inst_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25040105_imem_responder.sv
// Bench for the instruction-memory responder: three instances with
// LATENCY = 2, 1 and 15 share clock and reset; a word-level model of the
// store (associative array) supplies every expected response.
module tb_ysyx_25040105_imem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] SPAN  = 32'd16384;   // 4 * 2^12 bytes
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
    logic [31:0] req_addr  [3];
    logic [31:0] resp_inst [3];
    logic [31:0] load_addr [3];
    logic [31:0] load_data [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] model [int];
    int unsigned widx_q [$];
    logic [31:0] fault_addrs [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        ysyx_25040105_imem_responder #(
            .DEPTH_LOG2 (12),
            .BASE_ADDR  (BASE),
            .LATENCY    (gi == 0 ? 2 : (gi == 1 ? 1 : 15))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[gi]),
            .req_ready  (req_ready[gi]),
            .req_addr   (req_addr[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_ready (resp_ready[gi]),
            .resp_inst  (resp_inst[gi]),
            .resp_err   (resp_err[gi]),
            .load_en    (load_en[gi]),
            .load_addr  (load_addr[gi]),
            .load_data  (load_data[gi])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    function automatic int mk(input int d, input int idx);
        return d * 65536 + idx;
    endfunction

    // Address rules in plain arithmetic: aligned and within 4*4096 bytes above BASE.
    task automatic model_decode(input logic [31:0] addr, output bit err, output int idx);
        logic [31:0] offset;
        offset = addr - BASE;
        err    = (addr % 4 != 0) || (offset >= SPAN);
        idx    = int'(offset / 4);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Starts and ends just after a falling edge.
    task automatic do_load(input int d, input logic [31:0] addr, input logic [31:0] data);
        bit e;
        int idx;
        load_en[d]   = 1'b1;
        load_addr[d] = addr;
        load_data[d] = data;
        @(posedge clk);
        #1 load_en[d] = 1'b0;
        model_decode(addr, e, idx);
        if (!e) model[mk(d, idx)] = data;
        @(negedge clk);
    endtask

    // One fetch; bp = cycles of response backpressure. Returns the accept cycle.
    task automatic do_fetch(input int d, input logic [31:0] addr, input int bp, output int acc_cyc);
        bit          e;
        int          idx;
        int          n;
        bit          seen;
        logic [31:0] exp_inst;
        model_decode(addr, e, idx);
        exp_inst = e ? NOP : model[mk(d, idx)];
        req_valid[d]  = 1'b1;
        req_addr[d]   = addr;
        resp_ready[d] = (bp == 0);
        check_eq($sformatf("d%0d_ready_idle", d), 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        acc_cyc = cyc;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < lat_of(d) + 4) begin
            @(negedge clk);
            n++;
            if (resp_valid[d]) seen = 1'b1;
            else check_eq($sformatf("d%0d_ready_busy", d), 32'(req_ready[d]), 32'd0);
        end
        check_eq($sformatf("d%0d_latency a=%h", d, addr), 32'(n), 32'(lat_of(d)));
        check_eq($sformatf("d%0d_inst a=%h", d, addr), resp_inst[d], exp_inst);
        check_eq($sformatf("d%0d_err a=%h", d, addr), 32'(resp_err[d]), 32'(e));
        for (int k = 0; k < bp; k++) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("d%0d_bp_valid", d), 32'(resp_valid[d]), 32'd1);
            check_eq($sformatf("d%0d_bp_inst", d), resp_inst[d], exp_inst);
            check_eq($sformatf("d%0d_bp_err", d), 32'(resp_err[d]), 32'(e));
            check_eq($sformatf("d%0d_bp_ready", d), 32'(req_ready[d]), 32'd0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq($sformatf("d%0d_done_valid", d), 32'(resp_valid[d]), 32'd0);
        check_eq($sformatf("d%0d_done_ready", d), 32'(req_ready[d]), 32'd1);
    endtask

    function automatic logic [31:0] rand_fault_addr();
        logic [31:0] a;
        case ($urandom_range(0, 2))
            0:       a = BASE + 32'($urandom_range(0, 4095)) * 4 + 32'($urandom_range(1, 3));
            1:       a = BASE - 32'($urandom_range(1, 100000)) * 4;
            default: a = BASE + SPAN + 32'($urandom_range(0, 100000)) * 4;
        endcase
        return a;
    endfunction

    initial begin
        int          acc, prev_acc;
        int unsigned idx;
        logic [31:0] a;

        rst = 1'b0;
        req_valid = '0; resp_ready = '0; load_en = '0;
        for (int d = 0; d < 3; d++) begin
            req_addr[d] = '0; load_addr[d] = '0; load_data[d] = '0;
        end
        fault_addrs[0] = 32'h8000_0002;
        fault_addrs[1] = 32'h7FFF_FFFC;
        fault_addrs[2] = 32'h8000_4000;
        fault_addrs[3] = 32'h8000_3FFC;

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("d%0d_rst_ready", d), 32'(req_ready[d]), 32'd1);
            check_eq($sformatf("d%0d_rst_valid", d), 32'(resp_valid[d]), 32'd0);
            check_eq($sformatf("d%0d_rst_inst", d), resp_inst[d], 32'd0);
            check_eq($sformatf("d%0d_rst_err", d), 32'(resp_err[d]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Basic fetch of the ebreak word.
        do_load(0, BASE, 32'h0010_0073);
        do_fetch(0, BASE, 0, acc);

        // Program image: random words plus the last word of the store.
        for (int i = 0; i < 24; i++) begin
            idx = $urandom_range(1, 4095);
            widx_q.push_back(idx);
            for (int d = 0; d < 3; d++) do_load(d, BASE + idx * 4, $urandom);
        end
        widx_q.push_back(4095);
        for (int d = 0; d < 3; d++) do_load(d, 32'h8000_3FFC, $urandom);

        // Backpressure with a changing request address.
        do_fetch(0, BASE + widx_q[0] * 4, 5, acc);

        // Fault boundaries on every latency.
        for (int d = 0; d < 3; d++)
            for (int f = 0; f < 4; f++) do_fetch(d, fault_addrs[f], 0, acc);

        // Faulting loads must not alias onto word 0.
        do_load(0, BASE, 32'h1234_5678);
        do_load(0, BASE + SPAN, 32'hDEAD_0001);
        do_load(0, BASE + 1, 32'hDEAD_0002);
        do_load(0, BASE - 4, 32'hDEAD_0003);
        do_fetch(0, BASE, 0, acc);

        // Load to the same word on the edge that enters RESP.
        do_load(0, BASE + 20, 32'hAAAA_AAAA);
        req_valid[0]  = 1'b1;
        req_addr[0]   = BASE + 20;
        resp_ready[0] = 1'b0;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        load_en[0]   = 1'b1;
        load_addr[0] = BASE + 20;
        load_data[0] = 32'hBBBB_BBBB;
        @(posedge clk);
        #1 load_en[0] = 1'b0;
        model[mk(0, 5)] = 32'hBBBB_BBBB;
        @(negedge clk);
        check_eq("collide_valid", 32'(resp_valid[0]), 32'd1);
        check_eq("collide_inst", resp_inst[0], 32'hAAAA_AAAA);
        resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        do_fetch(0, BASE + 20, 0, acc);

        // Asynchronous reset in WAIT.
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE + 20;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("arst_valid", 32'(resp_valid[0]), 32'd0);
        check_eq("arst_inst", resp_inst[0], 32'd0);
        check_eq("arst_err", 32'(resp_err[0]), 32'd0);
        check_eq("arst_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_fetch(0, BASE + 20, 0, acc);

        // Randomized mix of valid and faulting fetches with random backpressure.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(0, 9) < 7) a = BASE + widx_q[$urandom_range(0, widx_q.size() - 1)] * 4;
                else a = rand_fault_addr();
                do_fetch(d, a, $urandom_range(0, 3), acc);
            end
        end

        // Back-to-back sweep: accept period must be LATENCY+1.
        for (int d = 1; d < 3; d++) begin
            prev_acc = 0;
            for (int i = 0; i < 8; i++) begin
                do_fetch(d, BASE + widx_q[$urandom_range(0, widx_q.size() - 1)] * 4, 0, acc);
                if (i > 0) check_eq($sformatf("d%0d_period", d), 32'(acc - prev_acc), 32'(lat_of(d) + 1));
                prev_acc = acc;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_25040105_imem_responder.md
Name: ysyx_25040105_imem_responder

Overview:
Instruction-memory responder that serves fetch requests from the core's IFU, returning the instruction word for a PC.
- Holds a word-addressed instruction store, a load port for the testbench/loader, and a request/response valid-ready handshake.
- Response latency is fixed by `LATENCY`, so the multi-cycle core can be exercised against non-zero memory latency.
- Sits between the IFU (initiator) and the program image.

Parameters:
- `DEPTH_LOG2`, default 12: log2 of the number of 32-bit words in the store.
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0.
- `LATENCY`, default 2: cycles from request accept to `resp_valid`; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  IFU presents a fetch address.
- `req_ready`  out  1  responder can accept a request.
- `req_addr`  in  32  fetch byte address (PC).
- `resp_valid`  out  1  response word available.
- `resp_ready`  in  1  IFU accepts the response.
- `resp_inst`  out  32  instruction word.
- `resp_err`  out  1  access fault: misaligned or out of range.
- `load_en`  in  1  write one word into the store.
- `load_addr`  in  32  byte address for the load write.
- `load_data`  in  32  word to write.

Behaviour:
- Reset (`rst`=0, asynchronous): state=IDLE, counter=0, `resp_valid`=0, `resp_inst`=0, `resp_err`=0, latched address=0. Store contents are not reset.
- `req_ready` is combinational: `req_ready`=(state==IDLE), so it is 1 during and after reset.
- States:
  - IDLE: on `req_valid` && `req_ready`, latch `req_addr`. If `LATENCY`==1, go to RESP; otherwise go to WAIT with counter=`LATENCY`-2.
  - WAIT: if counter==0, go to RESP; else decrement counter.
  - RESP: `resp_valid`=1. On `resp_ready`, go to IDLE.
- Registered outputs: `resp_inst` and `resp_err` are registered on the transition into RESP. `resp_valid` rises exactly `LATENCY` cycles after the accept edge.
- Only one request is outstanding. There is no accept in the same cycle as a response handshake, so back-to-back fetches cost `LATENCY`+1 cycles each.
- Backpressure: while in RESP with `resp_ready`=0, `resp_valid`, `resp_inst` and `resp_err` hold stable. `req_valid` is ignored.
- Address decode:
  - offset = `addr` − `BASE_ADDR`, 32-bit wraparound subtraction.
  - index = offset[`DEPTH_LOG2`+1:2].
  - out of range if offset ≥ 4·2^`DEPTH_LOG2`; this also catches `addr` < `BASE_ADDR` through the wraparound.
  - misaligned if `addr`[1:0] ≠ 0.
- Fault response: `resp_err`=1 and `resp_inst`=32'h0000_0013 (NOP). Otherwise `resp_err`=0 and `resp_inst`=store[index].
- Load writes:
  - Any cycle, any state: on `load_en` with a valid aligned in-range `load_addr`, write the store on the clock edge.
  - A faulting `load_addr` is silently dropped.
- Read/write collision: the store is read on the edge entering RESP. A load to the same word on that same edge is not visible; the old data is returned. Loads on earlier edges are visible.
- Reset mid-operation: any pending request is discarded. The IFU must reissue it after reset release.
- `req_addr` is sampled only at accept. Changes during WAIT and RESP are ignored.

Decomposition:
- Package `ysyx_25040105_imem_pkg` holds:
  - the state enum {IDLE, WAIT, RESP};
  - `NOP_INST`=32'h0000_0013;
  - a `WORD_BYTES`=4 constant;
  - an addr_check function returning {err, index}, shared by the read and load paths.
- Sub-module `ysyx_25040105_imem_array`: 2^`DEPTH_LOG2`×32 storage with one synchronous write port and one combinational read port. Keeps the FSM separate from the storage so the storage can later be swapped for an SRAM macro.

Test Plan:
1. Load 32'h0010_0073 at 32'h8000_0000; request 32'h8000_0000 with `LATENCY`=2, `resp_ready`=1 → `resp_valid` 2 cycles after accept, `resp_inst`=32'h0010_0073, `resp_err`=0, `req_ready`=0 until the handshake.
2. Backpressure: hold `resp_ready`=0 for 5 cycles with `req_valid`=1 and varying `req_addr` → outputs stable, no new accept; raise `resp_ready` → IDLE next cycle, `req_ready`=1.
3. Faults:
   - 32'h8000_0002 → `resp_err`=1, `resp_inst`=32'h0000_0013.
   - 32'h7FFF_FFFC → `resp_err`=1.
   - 32'h8000_4000 with `DEPTH_LOG2`=12 → `resp_err`=1.
   - 32'h8000_3FFC → `resp_err`=0.
4. Collision: word 5 = 32'hAAAA_AAAA; request word 5; load 32'hBBBB_BBBB to word 5 on the edge entering RESP → `resp_inst`=32'hAAAA_AAAA. A repeat fetch returns 32'hBBBB_BBBB.
5. Reset mid-operation: assert `rst`=0 asynchronously during WAIT → `resp_valid`=0, `resp_inst`=0 immediately. After release, `req_ready`=1 and a new fetch completes normally.
6. Latency sweep with `LATENCY`=1 and `LATENCY`=15: 8 sequential fetches each → `resp_valid` exactly `LATENCY` cycles after each accept; period `LATENCY`+1 with `resp_ready` tied 1.
